// File: rtl/data_mem_ctrl_if.sv
// Word-addressed req/ack data-memory bus between the load/store controller
// (master) and the data memory (slave).
interface data_mem_ctrl_if #(
    parameter int WIDTH = 32
);
    logic             bus_req;
    logic             bus_we;
    logic [WIDTH-1:0] bus_addr;
    logic [3:0]       bus_be;
    logic [WIDTH-1:0] bus_wdata;
    logic             bus_ack;
    logic [WIDTH-1:0] bus_rdata;

    modport master (
        output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        input  bus_ack, bus_rdata
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        output bus_ack, bus_rdata
    );
endinterface

// File: rtl/data_mem_ctrl.sv
// RV32I multi-cycle load/store controller: turns decoder load/store requests into
// req/ack bus cycles, stalls the core meanwhile and returns extended load data.
module data_mem_ctrl #(
    parameter int WIDTH          = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             mem_read,
    input  logic             mem_write,
    input  logic             one_byte,
    input  logic             two_bytes,
    input  logic             four_bytes,
    input  logic             load_unsigned,
    input  logic [WIDTH-1:0] addr,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data,
    output logic             stall,
    output logic             misaligned,
    output logic             bus_error,
    data_mem_ctrl_if.master  bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } size_e;

    localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    state_e           state_r;
    state_e           state_nxt_s;
    size_e            size_s;
    size_e            size_r;
    logic             op_s;
    logic             aligned_s;
    logic             start_s;
    logic             ack_s;
    logic             timeout_s;
    logic             unsigned_r;
    logic [1:0]       lane_r;
    logic [CNT_W-1:0] cnt_r;
    logic             bus_req_r;
    logic             bus_we_r;
    logic [WIDTH-1:0] bus_addr_r;
    logic [3:0]       bus_be_r;
    logic [WIDTH-1:0] bus_wdata_r;
    logic [WIDTH-1:0] rd_data_r;
    logic             bus_error_r;

    function automatic logic [3:0] lane_be(input size_e size, input logic [1:0] lo);
        logic [3:0] be;
        case (size)
            SZ_BYTE: be = 4'b0001 << lo;
            SZ_HALF: be = lo[1] ? 4'b1100 : 4'b0011;
            SZ_WORD: be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] lane_wdata(input size_e size, input logic [31:0] d);
        logic [31:0] w;
        case (size)
            SZ_BYTE: w = {4{d[7:0]}};
            SZ_HALF: w = {2{d[15:0]}};
            SZ_WORD: w = d;
            default: w = 32'h0000_0000;
        endcase
        return w;
    endfunction

    function automatic logic [31:0] load_extract(input size_e size, input logic [1:0] lo,
                                                 input logic uns, input logic [31:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] res;
        case (lo)
            2'b00:   b = word[7:0];
            2'b01:   b = word[15:8];
            2'b10:   b = word[23:16];
            2'b11:   b = word[31:24];
            default: b = 8'h00;
        endcase
        h = lo[1] ? word[31:16] : word[15:0];
        case (size)
            SZ_BYTE: res = uns ? {24'h00_0000, b} : {{24{b[7]}}, b};
            SZ_HALF: res = uns ? {16'h0000, h} : {{16{h[15]}}, h};
            SZ_WORD: res = word;
            default: res = 32'h0000_0000;
        endcase
        return res;
    endfunction

    // Decode the decoder request: access size (word if no flag) and alignment.
    always_comb begin
        op_s = mem_read | mem_write;
        if (four_bytes) begin
            size_s = SZ_WORD;
        end else if (two_bytes) begin
            size_s = SZ_HALF;
        end else if (one_byte) begin
            size_s = SZ_BYTE;
        end else begin
            size_s = SZ_WORD;
        end
        case (size_s)
            SZ_HALF: aligned_s = ~addr[0];
            SZ_WORD: aligned_s = (addr[1:0] == 2'b00);
            default: aligned_s = 1'b1;
        endcase
    end

    // Next-state logic; an ack in the final timeout cycle takes priority over the abort.
    always_comb begin
        state_nxt_s = state_r;
        start_s     = 1'b0;
        ack_s       = 1'b0;
        timeout_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (op_s && aligned_s) begin
                    start_s     = 1'b1;
                    state_nxt_s = ST_BUSY;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (bus.bus_ack) begin
                    ack_s       = 1'b1;
                    state_nxt_s = ST_DONE;
                end else if (cnt_r >= CNT_LAST) begin
                    timeout_s   = 1'b1;
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_BUSY;
                end
            end
            ST_DONE: state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Bus request, latched transfer attributes, timeout counter and load result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus_req_r   <= 1'b0;
            bus_we_r    <= 1'b0;
            bus_addr_r  <= '0;
            bus_be_r    <= 4'b0000;
            bus_wdata_r <= '0;
            size_r      <= SZ_BYTE;
            lane_r      <= 2'b00;
            unsigned_r  <= 1'b0;
            cnt_r       <= '0;
            rd_data_r   <= '0;
            bus_error_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start_s) begin
                        bus_req_r   <= 1'b1;
                        bus_we_r    <= mem_write;
                        bus_addr_r  <= {addr[WIDTH-1:2], 2'b00};
                        bus_be_r    <= lane_be(size_s, addr[1:0]);
                        bus_wdata_r <= lane_wdata(size_s, wr_data);
                        size_r      <= size_s;
                        lane_r      <= addr[1:0];
                        unsigned_r  <= load_unsigned;
                        cnt_r       <= '0;
                    end
                end
                ST_BUSY: begin
                    if (ack_s) begin
                        bus_req_r <= 1'b0;
                        rd_data_r <= bus_we_r ? 32'h0000_0000
                                              : load_extract(size_r, lane_r, unsigned_r, bus.bus_rdata);
                    end else if (timeout_s) begin
                        bus_req_r   <= 1'b0;
                        bus_error_r <= 1'b1;
                        rd_data_r   <= '0;
                    end else if (cnt_r != CNT_MAX) begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                // Result and error are only meaningful in DONE; clear them on the way out.
                ST_DONE: begin
                    bus_error_r <= 1'b0;
                    rd_data_r   <= '0;
                end
                default: begin
                    bus_req_r   <= 1'b0;
                    bus_error_r <= 1'b0;
                    rd_data_r   <= '0;
                end
            endcase
        end
    end

    assign stall         = ((state_r == ST_IDLE) & op_s & aligned_s) | (state_r == ST_BUSY);
    assign misaligned    = (state_r == ST_IDLE) & op_s & ~aligned_s;
    assign rd_data       = rd_data_r;
    assign bus_error     = bus_error_r;
    assign bus.bus_req   = bus_req_r;
    assign bus.bus_we    = bus_we_r;
    assign bus.bus_addr  = bus_addr_r;
    assign bus.bus_be    = bus_be_r;
    assign bus.bus_wdata = bus_wdata_r;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Self-checking bench for data_mem_ctrl: directed scenarios plus randomized
// back-to-back accesses compared against an arithmetic reference model.
module tb_data_mem_ctrl;
    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_read, mem_write, one_byte, two_bytes, four_bytes, load_unsigned;
    logic [31:0] addr, wr_data, rd_data;
    logic        stall, misaligned, bus_error;
    int          n_checks = 0;
    int          n_fail   = 0;

    always #5 clk = ~clk;

    data_mem_ctrl_if #(.WIDTH(32)) bus ();

    data_mem_ctrl #(.WIDTH(32), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n), .mem_read(mem_read), .mem_write(mem_write),
        .one_byte(one_byte), .two_bytes(two_bytes), .four_bytes(four_bytes),
        .load_unsigned(load_unsigned), .addr(addr), .wr_data(wr_data), .rd_data(rd_data),
        .stall(stall), .misaligned(misaligned), .bus_error(bus_error), .bus(bus)
    );

    typedef struct {
        logic        mis;
        logic [31:0] rd_idle;
        int          stall_cnt;
        int          req_cnt;
        int          cycles;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic        we;
        logic        stable;
        logic        err;
        logic [31:0] rdd;
    } obs_t;

    // Runs one instruction from its IDLE cycle to DONE, acting as the slave.
    // waits = number of BUSY cycles before ack; negative = never ack.
    task automatic do_access(input logic rd, input logic wr, input logic b1, input logic b2,
                             input logic b4, input logic uns, input logic [31:0] a,
                             input logic [31:0] wd, input logic [31:0] rdw, input int waits,
                             output obs_t o);
        o = '{default: 0};
        o.stable = 1'b1;
        @(negedge clk);
        mem_read = rd; mem_write = wr; one_byte = b1; two_bytes = b2; four_bytes = b4;
        load_unsigned = uns; addr = a; wr_data = wd;
        bus.bus_ack = 1'($urandom_range(0, 1));
        bus.bus_rdata = $urandom;
        for (int c = 0; c < 64; c++) begin
            #1;
            if (stall) o.stall_cnt++;
            if (c == 0) begin
                o.mis = misaligned;
                o.rd_idle = rd_data;
            end
            if (bus.bus_req) begin
                if (o.req_cnt == 0) begin
                    o.addr = bus.bus_addr; o.be = bus.bus_be; o.wdata = bus.bus_wdata; o.we = bus.bus_we;
                end else if (o.addr !== bus.bus_addr || o.be !== bus.bus_be ||
                             o.wdata !== bus.bus_wdata || o.we !== bus.bus_we) begin
                    o.stable = 1'b0;
                end
                bus.bus_ack = (waits >= 0 && o.req_cnt == waits);
                bus.bus_rdata = bus.bus_ack ? rdw : $urandom;
                o.req_cnt++;
                mem_read = 1'($urandom_range(0, 1)); mem_write = 1'($urandom_range(0, 1));
                one_byte = 1'($urandom_range(0, 1)); two_bytes = 1'($urandom_range(0, 1));
                four_bytes = 1'($urandom_range(0, 1)); load_unsigned = 1'($urandom_range(0, 1));
                addr = $urandom; wr_data = $urandom;
            end else if (c > 0) begin
                if (o.req_cnt > 0) begin
                    o.err = bus_error;
                    o.rdd = rd_data;
                end
                o.cycles = c + 1;
                mem_read = 1'b0; mem_write = 1'b0; one_byte = 1'b0; two_bytes = 1'b0;
                four_bytes = 1'b0; load_unsigned = 1'b0;
                bus.bus_ack = 1'($urandom_range(0, 1));
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        mem_write = 1'b1; four_bytes = 1'b1; addr = 32'h0000_0100; wr_data = 32'hCAFE_F00D;
        bus.bus_ack = 1'b1; bus.bus_rdata = 32'hFFFF_FFFF;
        repeat (3) @(negedge clk);
        #1;
        n_checks++; if (bus.bus_req !== 1'b0) begin n_fail++; $display("FAIL rst_req got %b exp 0", bus.bus_req); end
        n_checks++; if (bus.bus_be !== 4'b0000) begin n_fail++; $display("FAIL rst_be got %b exp 0000", bus.bus_be); end
        n_checks++; if (rd_data !== 32'h0) begin n_fail++; $display("FAIL rst_rd_data got %h exp 0", rd_data); end
        n_checks++; if (bus_error !== 1'b0) begin n_fail++; $display("FAIL rst_bus_error got %b exp 0", bus_error); end
        n_checks++; if (bus.bus_we !== 1'b0 || bus.bus_addr !== 32'h0 || bus.bus_wdata !== 32'h0) begin
            n_fail++; $display("FAIL rst_bus_regs got we=%b addr=%h wdata=%h exp all 0", bus.bus_we, bus.bus_addr, bus.bus_wdata);
        end
        n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL rst_stall got %b exp 1", stall); end
        addr = 32'h0000_0101;
        #1;
        n_checks++; if (misaligned !== 1'b1 || stall !== 1'b0) begin
            n_fail++; $display("FAIL rst_misaligned got mis=%b stall=%b exp 1/0", misaligned, stall);
        end
        @(negedge clk);
        mem_write = 1'b0; four_bytes = 1'b0; bus.bus_ack = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic test_store_word();
        obs_t o;
        do_access(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0, 0, o);
        n_checks++; if (o.addr !== 32'h0000_0100) begin n_fail++; $display("FAIL sw_addr got %h exp 00000100", o.addr); end
        n_checks++; if (o.be !== 4'b1111) begin n_fail++; $display("FAIL sw_be got %b exp 1111", o.be); end
        n_checks++; if (o.wdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL sw_wdata got %h exp deadbeef", o.wdata); end
        n_checks++; if (o.we !== 1'b1) begin n_fail++; $display("FAIL sw_we got %b exp 1", o.we); end
        n_checks++; if (o.stall_cnt != 2 || o.cycles != 3) begin
            n_fail++; $display("FAIL sw_timing got stall=%0d cycles=%0d exp 2/3", o.stall_cnt, o.cycles);
        end
    endtask

    task automatic test_store_sub();
        obs_t o;
        do_access(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0103, 32'h0000_00A5, 32'h0, 1, o);
        n_checks++; if (o.addr !== 32'h0000_0100 || o.be !== 4'b1000 || o.wdata !== 32'hA5A5_A5A5) begin
            n_fail++; $display("FAIL sb_lanes got addr=%h be=%b wdata=%h exp 00000100/1000/a5a5a5a5", o.addr, o.be, o.wdata);
        end
        do_access(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0102, 32'h0000_1234, 32'h0, 0, o);
        n_checks++; if (o.be !== 4'b1100 || o.wdata !== 32'h1234_1234) begin
            n_fail++; $display("FAIL sh_lanes got be=%b wdata=%h exp 1100/12341234", o.be, o.wdata);
        end
    endtask

    task automatic test_loads();
        obs_t o;
        do_access(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0102, 32'h0, 32'h12F4_5678, 3, o);
        n_checks++; if (o.rdd !== 32'hFFFF_FFF4) begin n_fail++; $display("FAIL lb_data got %h exp fffffff4", o.rdd); end
        n_checks++; if (o.stall_cnt != 5 || o.cycles != 6) begin
            n_fail++; $display("FAIL lb_timing got stall=%0d cycles=%0d exp 5/6", o.stall_cnt, o.cycles);
        end
        n_checks++; if (o.we !== 1'b0 || o.be !== 4'b0100) begin
            n_fail++; $display("FAIL lb_bus got we=%b be=%b exp 0/0100", o.we, o.be);
        end
        do_access(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0102, 32'h0, 32'h12F4_5678, 3, o);
        n_checks++; if (o.rdd !== 32'h0000_00F4) begin n_fail++; $display("FAIL lbu_data got %h exp 000000f4", o.rdd); end
        do_access(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0102, 32'h0, 32'h12F4_5678, 3, o);
        n_checks++; if (o.rdd !== 32'h0000_12F4) begin n_fail++; $display("FAIL lh_data got %h exp 000012f4", o.rdd); end
        do_access(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0100, 32'h0, 32'h12F4_5678, 3, o);
        n_checks++; if (o.rdd !== 32'h12F4_5678) begin n_fail++; $display("FAIL lw_data got %h exp 12f45678", o.rdd); end
    endtask

    task automatic test_misaligned();
        obs_t o;
        do_access(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0101, 32'h0, 32'h0, 0, o);
        n_checks++; if (o.mis !== 1'b1 || o.req_cnt != 0 || o.stall_cnt != 0 || o.rd_idle !== 32'h0) begin
            n_fail++; $display("FAIL lw_misaligned got mis=%b req=%0d stall=%0d rd=%h exp 1/0/0/0", o.mis, o.req_cnt, o.stall_cnt, o.rd_idle);
        end
        do_access(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0203, 32'h0000_BEEF, 32'h0, 0, o);
        n_checks++; if (o.mis !== 1'b1 || o.req_cnt != 0 || o.stall_cnt != 0 || o.rd_idle !== 32'h0) begin
            n_fail++; $display("FAIL sh_misaligned got mis=%b req=%0d stall=%0d rd=%h exp 1/0/0/0", o.mis, o.req_cnt, o.stall_cnt, o.rd_idle);
        end
    endtask

    task automatic test_timeout();
        obs_t o;
        do_access(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0400, 32'h0, 32'h5555_AAAA, -1, o);
        n_checks++; if (o.req_cnt != TO) begin n_fail++; $display("FAIL to_req_cycles got %0d exp %0d", o.req_cnt, TO); end
        n_checks++; if (o.err !== 1'b1 || o.rdd !== 32'h0) begin
            n_fail++; $display("FAIL to_done got err=%b rd=%h exp 1/0", o.err, o.rdd);
        end
        @(negedge clk);
        #1;
        n_checks++; if (bus_error !== 1'b0 || bus.bus_req !== 1'b0) begin
            n_fail++; $display("FAIL to_idle got err=%b req=%b exp 0/0", bus_error, bus.bus_req);
        end
        do_access(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0400, 32'h0, 32'h5555_AAAA, TO - 1, o);
        n_checks++; if (o.err !== 1'b0 || o.req_cnt != TO || o.rdd !== 32'h5555_AAAA) begin
            n_fail++; $display("FAIL to_last_ack got err=%b req=%0d rd=%h exp 0/%0d/5555aaaa", o.err, o.req_cnt, o.rdd, TO);
        end
    endtask

    task automatic test_flags();
        obs_t o;
        do_access(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0010, 32'h0BAD_F00D, 32'h0, 0, o);
        n_checks++; if (o.we !== 1'b1 || o.wdata !== 32'h0BAD_F00D) begin
            n_fail++; $display("FAIL rw_is_write got we=%b wdata=%h exp 1/0badf00d", o.we, o.wdata);
        end
        do_access(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0020, 32'h0, 32'h8765_4321, 1, o);
        n_checks++; if (o.be !== 4'b1111 || o.rdd !== 32'h8765_4321) begin
            n_fail++; $display("FAIL nosize_word got be=%b rd=%h exp 1111/87654321", o.be, o.rdd);
        end
    endtask

    task automatic test_back_to_back();
        obs_t        o;
        logic        rd, wr, b1, b2, b4, uns, acked, ok_align;
        logic [31:0] a, wd, rdw, ewd, eld, mask;
        logic [3:0]  ebe;
        int          w, n, off, exp_req;
        for (int i = 0; i < 150; i++) begin
            rd = 1'($urandom_range(0, 1)); wr = 1'($urandom_range(0, 1));
            if (!rd && !wr) rd = 1'b1;
            b1 = 1'($urandom_range(0, 1)); b2 = 1'($urandom_range(0, 1)); b4 = 1'($urandom_range(0, 1));
            uns = 1'($urandom_range(0, 1));
            a = $urandom; wd = $urandom; rdw = $urandom;
            case ($urandom_range(0, 9))
                0:       w = -1;
                1:       w = TO - 1;
                default: w = int'($urandom_range(0, 4));
            endcase
            // Reference model: plain arithmetic on byte count and byte offset.
            n = b4 ? 4 : (b2 ? 2 : (b1 ? 1 : 4));
            off = int'(a[1:0]);
            ok_align = (off % n) == 0;
            ebe = 4'(((1 << n) - 1) << off);
            ewd = (n == 1) ? ({24'h0, wd[7:0]} * 32'h0101_0101) :
                  (n == 2) ? ({16'h0, wd[15:0]} * 32'h0001_0001) : wd;
            mask = (n == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * n)) - 32'd1);
            eld = (rdw >> (8 * off)) & mask;
            if (!uns && n != 4 && eld[8 * n - 1]) eld = eld | ~mask;
            acked = (w >= 0 && w < TO);
            exp_req = acked ? w + 1 : TO;
            do_access(rd, wr, b1, b2, b4, uns, a, wd, rdw, w, o);
            n_checks++; if (o.mis !== !ok_align) begin n_fail++; $display("FAIL rnd%0d_mis got %b exp %b", i, o.mis, !ok_align); end
            if (!ok_align) begin
                n_checks++; if (o.req_cnt != 0 || o.stall_cnt != 0 || o.rd_idle !== 32'h0) begin
                    n_fail++; $display("FAIL rnd%0d_mis_quiet got req=%0d stall=%0d rd=%h exp 0/0/0", i, o.req_cnt, o.stall_cnt, o.rd_idle);
                end
            end else begin
                n_checks++; if (o.addr !== (a & ~32'd3) || o.be !== ebe || o.we !== wr) begin
                    n_fail++; $display("FAIL rnd%0d_bus got addr=%h be=%b we=%b exp %h/%b/%b", i, o.addr, o.be, o.we, a & ~32'd3, ebe, wr);
                end
                if (wr) begin
                    n_checks++; if (o.wdata !== ewd) begin n_fail++; $display("FAIL rnd%0d_wdata got %h exp %h", i, o.wdata, ewd); end
                end
                n_checks++; if (o.stable !== 1'b1) begin n_fail++; $display("FAIL rnd%0d_bus_hold got %b exp 1", i, o.stable); end
                n_checks++; if (o.req_cnt != exp_req || o.stall_cnt != exp_req + 1 || o.cycles != exp_req + 2) begin
                    n_fail++; $display("FAIL rnd%0d_timing got req=%0d stall=%0d cyc=%0d exp %0d/%0d/%0d",
                                       i, o.req_cnt, o.stall_cnt, o.cycles, exp_req, exp_req + 1, exp_req + 2);
                end
                n_checks++; if (o.err !== !acked) begin n_fail++; $display("FAIL rnd%0d_err got %b exp %b", i, o.err, !acked); end
                if (!wr || !acked) begin
                    n_checks++; if (o.rdd !== (acked ? eld : 32'h0)) begin
                        n_fail++; $display("FAIL rnd%0d_rd_data got %h exp %h", i, o.rdd, acked ? eld : 32'h0);
                    end
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        obs_t o;
        @(negedge clk);
        mem_read = 1'b1; four_bytes = 1'b1; addr = 32'h0000_0300; bus.bus_ack = 1'b0;
        @(posedge clk);
        #1;
        mem_read = 1'b0; four_bytes = 1'b0;
        @(posedge clk);
        #2;
        n_checks++; if (bus.bus_req !== 1'b1) begin n_fail++; $display("FAIL mid_busy_req got %b exp 1", bus.bus_req); end
        rst_n = 1'b0;
        #1;
        n_checks++; if (bus.bus_req !== 1'b0 || stall !== 1'b0) begin
            n_fail++; $display("FAIL mid_async_drop got req=%b stall=%b exp 0/0", bus.bus_req, stall);
        end
        @(negedge clk);
        rst_n = 1'b1; bus.bus_ack = 1'b1; bus.bus_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        #1;
        n_checks++; if (bus.bus_req !== 1'b0 || rd_data !== 32'h0 || bus_error !== 1'b0) begin
            n_fail++; $display("FAIL mid_late_ack got req=%b rd=%h err=%b exp 0/0/0", bus.bus_req, rd_data, bus_error);
        end
        bus.bus_ack = 1'b0;
        do_access(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0302, 32'h0, 32'h9ABC_0000, 2, o);
        n_checks++; if (o.rdd !== 32'h0000_9ABC || o.cycles != 5) begin
            n_fail++; $display("FAIL mid_recover got rd=%h cycles=%0d exp 00009abc/5", o.rdd, o.cycles);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        mem_read = 1'b0; mem_write = 1'b0; one_byte = 1'b0; two_bytes = 1'b0; four_bytes = 1'b0;
        load_unsigned = 1'b0; addr = 32'h0; wr_data = 32'h0;
        bus.bus_ack = 1'b0; bus.bus_rdata = 32'h0;
        test_reset();
        test_store_word();
        test_store_sub();
        test_loads();
        test_misaligned();
        test_timeout();
        test_flags();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
